// File: rtl/alu_pkg.sv
// Shared ALU encodings, skid-buffer state codes and width helpers for the
// EX-stage result path.
package alu_pkg;

   // Source index of each ALU function-unit result on the selector input
   localparam logic [1:0] SEL_AND  = 2'd0;
   localparam logic [1:0] SEL_OR   = 2'd1;
   localparam logic [1:0] SEL_SUM  = 2'd2;
   localparam logic [1:0] SEL_LESS = 2'd3;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } skid_state_e;

   // Bits needed to index n items, never less than one
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : alu_pkg

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer; ready and valid come from
// registered state only, so out_ready never reaches in_ready combinationally.
module pipe_skid_buf
   import alu_pkg::*;
#(
   parameter int unsigned    DW      = 8,
   parameter logic [DW-1:0]  RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   skid_state_e   state_q, state_d;
   logic [DW-1:0] m_q, m_d;
   logic [DW-1:0] s_q, s_d;
   logic          in_xfer;
   logic          out_xfer;

   // Handshake decode; held low while rst so nothing transfers on a reset edge
   assign in_ready  = !rst && (state_q != TWO);
   assign out_valid = !rst && (state_q != EMPTY);
   assign out_data  = m_q;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               m_d     = in_data;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_d = TWO;
               s_d     = in_data;
            end else if (out_xfer && !in_xfer) begin
               state_d = EMPTY;
            end else if (in_xfer && out_xfer) begin
               m_d     = in_data;
            end
         end
         TWO: begin
            // Skid entry moves up to the head once the head drains
            if (out_xfer) begin
               state_d = ONE;
               m_d     = s_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         m_q     <= RST_VAL;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         s_q     <= s_d;
      end
   end

endmodule : pipe_skid_buf

// File: rtl/alu_result_sel_pipe.sv
// N-way ALU result selector with zero/illegal-select flags, registered behind
// a two-entry skid buffer feeding the EX/MEM register.
module alu_result_sel_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_IN  = 4,
   parameter int unsigned SEL_W = clog2(N_IN)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_zero,
   output logic                  out_err,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned DW = WIDTH + 2;
   // Empty-pipe head presents a zero result with its zero flag set
   localparam logic [DW-1:0] HEAD_RST = {WIDTH'(0), 1'b1, 1'b0};

   logic [WIDTH-1:0] sel_data_c;
   logic             sel_err_c;
   logic             sel_zero_c;
   logic [DW-1:0]    beat_c;
   logic [DW-1:0]    head;

   // Codes with no matching source fall through to the zero/err defaults
   always_comb begin
      sel_data_c = '0;
      sel_err_c  = 1'b1;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_data_c = in_data[k*WIDTH +: WIDTH];
            sel_err_c  = 1'b0;
         end
      end
   end

   assign sel_zero_c = (sel_data_c == '0);
   assign beat_c     = {sel_data_c, sel_zero_c, sel_err_c};

   pipe_skid_buf #(
      .DW      (DW),
      .RST_VAL (HEAD_RST)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (beat_c),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (head),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_data = head[DW-1:2];
   assign out_zero = head[1];
   assign out_err  = head[0];

endmodule : alu_result_sel_pipe

// File: tb/tb_alu_result_sel_pipe.sv
// Directed bench: a 4-source and a 3-source selector driven side by side.
module tb_alu_result_sel_pipe;
   import alu_pkg::*;

   logic          clk;
   logic          rst;
   logic [1:0]    in_sel;
   logic          in_valid;
   logic          out_ready;
   logic [127:0]  in_data4;
   logic [95:0]   in_data3;
   logic          in_ready4, in_ready3;
   logic [31:0]   out_data4, out_data3;
   logic          out_zero4, out_zero3;
   logic          out_err4, out_err3;
   logic          out_valid4, out_valid3;

   int n_cmp;
   int n_bad;

   alu_result_sel_pipe #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data4),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .out_data  (out_data4),
      .out_zero  (out_zero4),
      .out_err   (out_err4),
      .out_valid (out_valid4),
      .out_ready (out_ready)
   );

   alu_result_sel_pipe #(.WIDTH(32), .N_IN(3), .SEL_W(2)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data3),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_zero  (out_zero3),
      .out_err   (out_err3),
      .out_valid (out_valid3),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic [1:0]   sel;
      logic [31:0]  d4;
      logic         z4;
      logic         e4;
      logic [31:0]  d3;
      logic         z3;
      logic         e3;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [127:0] d, input logic [1:0] s, input logic v);
      in_data4 = d;
      in_data3 = d[95:0];
      in_sel   = s;
      in_valid = v;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      out_ready = 1'b1;
      drive('0, 2'd0, 1'b0);

      vecs[0] = '{{32'h4, 32'h3, 32'h2, 32'h1}, SEL_SUM,
                  32'h3, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0};
      vecs[1] = '{{32'h4, 32'h3, 32'h2, 32'h1}, SEL_LESS,
                  32'h4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
      vecs[2] = '{{32'h0, 32'h0, 32'h5, 32'h0}, SEL_AND,
                  32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
      vecs[3] = '{{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h1234_5678}, SEL_SUM,
                  32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
      vecs[4] = '{{32'h0, 32'h0, 32'h0, 32'h0}, SEL_LESS,
                  32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1};

      // Reset state
      step();
      step();
      chk("rst_in_ready", 32'(in_ready4), 32'd0);
      chk("rst_out_valid", 32'(out_valid4), 32'd0);
      chk("rst_out_data", out_data4, 32'h0);
      chk("rst_out_zero", 32'(out_zero4), 32'd1);
      chk("rst_out_err", 32'(out_err4), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready4), 32'd1);
      chk("post_rst_in_ready3", 32'(in_ready3), 32'd1);
      @(negedge clk);

      // Single beats from the table
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].data, vecs[i].sel, 1'b1);
         step();
         chk($sformatf("v%0d_valid4", i), 32'(out_valid4), 32'd1);
         chk($sformatf("v%0d_data4", i), out_data4, vecs[i].d4);
         chk($sformatf("v%0d_zero4", i), 32'(out_zero4), 32'(vecs[i].z4));
         chk($sformatf("v%0d_err4", i), 32'(out_err4), 32'(vecs[i].e4));
         chk($sformatf("v%0d_valid3", i), 32'(out_valid3), 32'd1);
         chk($sformatf("v%0d_data3", i), out_data3, vecs[i].d3);
         chk($sformatf("v%0d_zero3", i), 32'(out_zero3), 32'(vecs[i].z3));
         chk($sformatf("v%0d_err3", i), 32'(out_err3), 32'(vecs[i].e3));
         in_valid = 1'b0;
         step();
         chk($sformatf("v%0d_drain4", i), 32'(out_valid4), 32'd0);
         chk($sformatf("v%0d_drain3", i), 32'(out_valid3), 32'd0);
      end

      // Streaming, one beat per cycle
      for (int i = 0; i < 4; i++) begin
         drive({32'h4, 32'h3, 32'h2, 32'h1}, 2'(i), 1'b1);
         step();
         chk($sformatf("stream%0d_ready", i), 32'(in_ready4), 32'd1);
         chk($sformatf("stream%0d_valid", i), 32'(out_valid4), 32'd1);
         chk($sformatf("stream%0d_data", i), out_data4, 32'(i + 1));
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain", 32'(out_valid4), 32'd0);

      // Backpressure into the skid entry
      out_ready = 1'b0;
      drive({96'h0, 32'hAAAA}, SEL_AND, 1'b1);
      step();
      chk("bp_a_valid", 32'(out_valid4), 32'd1);
      chk("bp_a_ready", 32'(in_ready4), 32'd1);
      chk("bp_a_data", out_data4, 32'hAAAA);
      drive({96'h0, 32'hBBBB}, SEL_AND, 1'b1);
      step();
      chk("bp_full_ready", 32'(in_ready4), 32'd0);
      chk("bp_full_data", out_data4, 32'hAAAA);
      in_valid = 1'b0;
      step();
      chk("bp_hold_valid", 32'(out_valid4), 32'd1);
      chk("bp_hold_data", out_data4, 32'hAAAA);
      out_ready = 1'b1;
      step();
      chk("bp_b_valid", 32'(out_valid4), 32'd1);
      chk("bp_b_data", out_data4, 32'hBBBB);
      chk("bp_b_ready", 32'(in_ready4), 32'd1);
      step();
      chk("bp_drain", 32'(out_valid4), 32'd0);

      // Reset while both entries are full
      out_ready = 1'b0;
      drive({96'h0, 32'hC0C0}, SEL_AND, 1'b1);
      step();
      drive({96'h0, 32'hD0D0}, SEL_AND, 1'b1);
      step();
      chk("mr_full_ready", 32'(in_ready4), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("mr_during_valid", 32'(out_valid4), 32'd0);
      chk("mr_during_ready", 32'(in_ready4), 32'd0);
      @(negedge clk);
      step();
      rst = 1'b0;
      #1;
      chk("mr_after_valid", 32'(out_valid4), 32'd0);
      chk("mr_after_ready", 32'(in_ready4), 32'd1);
      chk("mr_after_data", out_data4, 32'h0);
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("mr_no_ghost%0d", i), 32'(out_valid4), 32'd0);
      end

      // Simultaneous accept and deliver while holding one entry
      for (int i = 0; i < 6; i++) begin
         drive({64'h0, 32'(32'h100 + i), 32'h0}, SEL_OR, 1'b1);
         step();
         chk($sformatf("sim%0d_valid", i), 32'(out_valid4), 32'd1);
         chk($sformatf("sim%0d_ready", i), 32'(in_ready4), 32'd1);
         chk($sformatf("sim%0d_data", i), out_data4, 32'(32'h100 + i));
      end
      in_valid = 1'b0;
      step();
      chk("sim_drain", 32'(out_valid4), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_alu_result_sel_pipe
